// File: rtl/fht_adc_loader.sv
`timescale 1ns/1ps
// Purpose: loads one frame of 4*2^A_BIT ADC samples into the four FHT banks, then starts the transform.
// Latency: a sample accepted at edge k shows up on oWE/oDATA/oADDR_WR after edge k; oSTART follows one edge after the last write.
// Backpressure: oADC_READY is low from the last sample of a frame until the transform reports done on iFHT_RDY.
//
// Ports:
//   iCLK, iRESET (async, active-low)
//   iADC_DATA/iADC_VALID/oADC_READY  sample stream handshake
//   iFHT_RDY                         fht_top oRDY (low while the transform runs)
//   oWE/oDATA/oADDR_WR               bank write port (one-hot bank enable)
//   oSTART/oBUSY/oFRAME_CNT          transform control and status
module fht_adc_loader #(
    parameter int D_BIT     = 18,
    parameter int ADC_WIDTH = 14,
    parameter int A_BIT     = 8,
    parameter int LSH       = 0,
    parameter int BITREV    = 0
) (
    input  logic                 iCLK,
    input  logic                 iRESET,
    input  logic [ADC_WIDTH-1:0] iADC_DATA,
    input  logic                 iADC_VALID,
    output logic                 oADC_READY,
    input  logic                 iFHT_RDY,
    output logic [3:0]           oWE,
    output logic [D_BIT-1:0]     oDATA,
    output logic [A_BIT-1:0]     oADDR_WR,
    output logic                 oSTART,
    output logic                 oBUSY,
    output logic [7:0]           oFRAME_CNT
);

    localparam int NB = A_BIT + 2;

    typedef enum logic [1:0] {LOAD, START, WAIT_LOW, WAIT_HIGH} state_t;

    state_t          state;
    logic [NB-1:0]   n;
    logic [NB-1:0]   m;
    logic [D_BIT-1:0] data_ext;
    logic            xfer;
    logic            last;

    // Optional bit reversal of the global sample index before the bank/address split.
    generate
        if (BITREV == 1) begin : g_rev
            for (genvar i = 0; i < NB; i++) begin : g_bit
                assign m[i] = n[NB-1-i];
            end
        end else begin : g_lin
            assign m = n;
        end
    endgenerate

    // Sign-extend to the transform width, then scale; the width rule
    // D_BIT >= ADC_WIDTH + LSH keeps the shifted value in range.
    assign data_ext = D_BIT'($signed(iADC_DATA)) << LSH;

    assign xfer = (state == LOAD) && iADC_VALID && oADC_READY;
    assign last = &n;

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state      <= LOAD;
            n          <= '0;
            oADC_READY <= 1'b0;
            oWE        <= 4'b0000;
            oDATA      <= '0;
            oADDR_WR   <= '0;
            oSTART     <= 1'b0;
            oBUSY      <= 1'b0;
            oFRAME_CNT <= 8'd0;
        end else begin
            // Write enable and start are single-cycle strobes.
            oWE    <= 4'b0000;
            oSTART <= 1'b0;
            case (state)
                LOAD: begin
                    oADC_READY <= 1'b1;
                    if (xfer) begin
                        oWE      <= 4'b0001 << m[1:0];
                        oADDR_WR <= m[NB-1:2];
                        oDATA    <= data_ext;
                        if (last) begin
                            n          <= '0;
                            oADC_READY <= 1'b0;
                            state      <= START;
                        end else begin
                            n <= n + 1'b1;
                        end
                    end
                end
                START: begin
                    oADC_READY <= 1'b0;
                    oSTART     <= 1'b1;
                    oBUSY      <= 1'b1;
                    state      <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    // Wait until the transform has visibly started.
                    if (!iFHT_RDY) state <= WAIT_HIGH;
                end
                WAIT_HIGH: begin
                    if (iFHT_RDY) begin
                        oBUSY      <= 1'b0;
                        oFRAME_CNT <= oFRAME_CNT + 8'd1;
                        oADC_READY <= 1'b1;
                        state      <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_fht_adc_loader.sv
`timescale 1ns/1ps
// Bench for fht_adc_loader: three instances (linear, bit-reversed, LSH=2) share
// one sample stream; a RAM model per instance collects bank writes.
module tb_fht_adc_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] adc_data = '0;
    logic        adc_valid = 1'b0;
    logic        fht_rdy = 1'b1;

    logic        ready [3];
    logic [3:0]  we    [3];
    logic [17:0] data  [3];
    logic [7:0]  addr  [3];
    logic        start [3];
    logic        busy  [3];
    logic [7:0]  cnt   [3];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fht_adc_loader #(.BITREV(0), .LSH(0)) dut_lin (
        .iCLK(clk), .iRESET(rst_n), .iADC_DATA(adc_data), .iADC_VALID(adc_valid),
        .oADC_READY(ready[0]), .iFHT_RDY(fht_rdy), .oWE(we[0]), .oDATA(data[0]),
        .oADDR_WR(addr[0]), .oSTART(start[0]), .oBUSY(busy[0]), .oFRAME_CNT(cnt[0]));
    fht_adc_loader #(.BITREV(1), .LSH(0)) dut_rev (
        .iCLK(clk), .iRESET(rst_n), .iADC_DATA(adc_data), .iADC_VALID(adc_valid),
        .oADC_READY(ready[1]), .iFHT_RDY(fht_rdy), .oWE(we[1]), .oDATA(data[1]),
        .oADDR_WR(addr[1]), .oSTART(start[1]), .oBUSY(busy[1]), .oFRAME_CNT(cnt[1]));
    fht_adc_loader #(.BITREV(0), .LSH(2)) dut_sh (
        .iCLK(clk), .iRESET(rst_n), .iADC_DATA(adc_data), .iADC_VALID(adc_valid),
        .oADC_READY(ready[2]), .iFHT_RDY(fht_rdy), .oWE(we[2]), .oDATA(data[2]),
        .oADDR_WR(addr[2]), .oSTART(start[2]), .oBUSY(busy[2]), .oFRAME_CNT(cnt[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RAM models and write monitor
    logic [17:0] ram [3][4][256];
    int onehot_err = 0;
    int busy_wr = 0;
    int start_cnt = 0;
    int start_long = 0;
    logic start_prev = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 3; d++) begin
                if (we[d] != 4'b0000) begin
                    int b;
                    if (!$onehot(we[d])) onehot_err++;
                    if (busy[d]) busy_wr++;
                    b = we[d][3] ? 3 : we[d][2] ? 2 : we[d][1] ? 1 : 0;
                    ram[d][b][addr[d]] = data[d];
                end
            end
            if (start[0]) begin
                start_cnt++;
                if (start_prev) start_long++;
            end
            start_prev = start[0];
        end else begin
            start_prev = 1'b0;
        end
    end

    function automatic logic [17:0] sx(input logic [13:0] v, input int sh);
        logic [17:0] e;
        e = {{4{v[13]}}, v};
        return e << sh;
    endfunction

    function automatic logic [9:0] rev10(input logic [9:0] x);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = x[9-i];
        return r;
    endfunction

    function automatic logic [13:0] sval(input int f, input int n);
        logic [31:0] t;
        if (f == 1) t = n - 512;
        else if (f == 2) t = (n == 0) ? 32'h2000 : (n == 1) ? 32'h1FFF : n * 37 + 5;
        else t = (n * 91 + 1234) ^ 32'h2A5;
        return t[13:0];
    endfunction

    function automatic int outs_nz();
        int c = 0;
        for (int d = 0; d < 3; d++) begin
            c += int'(we[d] != 0) + int'(data[d] != 0) + int'(addr[d] != 0) + int'(start[d])
               + int'(busy[d]) + int'(cnt[d] != 0) + int'(ready[d]);
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ram();
        for (int d = 0; d < 3; d++)
            for (int b = 0; b < 4; b++)
                for (int a = 0; a < 256; a++)
                    ram[d][b][a] = 18'h2AAAA;
    endtask

    task automatic check_ram(input int f, input string tag);
        int e0 = 0, e1 = 0, e2 = 0;
        for (int n = 0; n < 1024; n++) begin
            logic [9:0] nn, mr;
            logic [13:0] v;
            nn = n[9:0];
            mr = rev10(nn);
            v  = sval(f, n);
            if (ram[0][nn[1:0]][nn[9:2]] !== sx(v, 0)) e0++;
            if (ram[1][mr[1:0]][mr[9:2]] !== sx(v, 0)) e1++;
            if (ram[2][nn[1:0]][nn[9:2]] !== sx(v, 2)) e2++;
        end
        chk({tag, "_ram_lin"}, e0, 0);
        chk({tag, "_ram_rev"}, e1, 0);
        chk({tag, "_ram_sh"}, e2, 0);
    endtask

    // Present one sample and return just after the edge that accepts it.
    task automatic push(input logic [13:0] d);
        int t = 0;
        adc_data  = d;
        adc_valid = 1'b1;
        while (!ready[0] && t < 500) begin
            tick();
            t++;
        end
        if (t >= 500) chk("push_timeout", t, 0);
        tick();
        adc_valid = 1'b0;
    endtask

    task automatic run_frame(input int f, input bit gaps);
        for (int n = 0; n < 1024; n++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            push(sval(f, n));
            if (f == 1 && n == 1) begin
                chk("rev_s1_we", we[1], 4'b0001);
                chk("rev_s1_addr", addr[1], 8'd128);
            end
            if (f == 1 && n == 2) begin
                chk("rev_s2_we", we[1], 4'b0001);
                chk("rev_s2_addr", addr[1], 8'd64);
            end
            if (f == 1 && n == 5) begin
                chk("lin_s5_we", we[0], 4'b0010);
                chk("lin_s5_addr", addr[0], 8'd1);
                chk("lin_s5_data", data[0], 18'h3FE05);
            end
            if (f == 1 && n == 1023) begin
                chk("lin_s1023_we", we[0], 4'b1000);
                chk("lin_s1023_addr", addr[0], 8'd255);
            end
            if (f == 2 && n == 0) begin
                chk("f2_first_we", we[0], 4'b0001);
                chk("f2_first_addr", addr[0], 8'd0);
                chk("sh_2000", data[2], 18'h38000);
                chk("lin_2000", data[0], 18'h3E000);
            end
            if (f == 2 && n == 1) begin
                chk("sh_1fff", data[2], 18'h07FFC);
                chk("lin_1fff", data[0], 18'h01FFF);
            end
        end
    endtask

    // Called right after the last sample's edge. Holds valid high while the
    // transform model runs: rdy stays high hi_cycles, then low lo_cycles.
    task automatic finish_frame(input int hi_cycles, input int lo_cycles, input int exp_cnt);
        int s0 = start_cnt;
        int bp = 0;
        chk("ready_low_after_last", ready[0], 1'b0);
        adc_valid = 1'b1;
        if (hi_cycles == 0) fht_rdy = 1'b0;
        tick();
        chk("start_busy", {start[0], start[1], start[2], busy[0], busy[1], busy[2]}, 6'b111111);
        repeat (hi_cycles) begin
            tick();
            if (ready[0] || we[0] != 0 || !busy[0]) bp++;
        end
        fht_rdy = 1'b0;
        repeat (lo_cycles) begin
            tick();
            if (ready[0] || ready[1] || ready[2] || we[0] != 0 || we[1] != 0 || we[2] != 0 || !busy[0]) bp++;
        end
        chk("backpressure", bp, 0);
        fht_rdy = 1'b1;
        tick();
        chk("done_busy", busy[0], 1'b0);
        chk("done_cnt", cnt[0], exp_cnt);
        chk("done_cnt_rev", cnt[1], exp_cnt);
        chk("done_ready", ready[0], 1'b1);
        adc_valid = 1'b0;
        chk("start_once", start_cnt - s0, 1);
    endtask

    initial begin
        // Reset with valid asserted
        adc_valid = 1'b1;
        adc_data  = 14'h1234;
        repeat (3) tick();
        chk("rst_outputs", outs_nz(), 0);
        rst_n = 1'b1;
        chk("ready_before_edge", ready[0], 1'b0);
        adc_valid = 1'b0;
        tick();
        chk("ready_after_release", {ready[0], ready[1], ready[2]}, 3'b111);
        chk("no_we_after_release", we[0], 4'b0000);

        // Frame 1: linear ramp; transform drops rdy immediately for 100 cycles
        clear_ram();
        run_frame(1, 1'b0);
        finish_frame(0, 100, 1);
        check_ram(1, "f1");

        // Frame 2: sign/shift corner samples; rdy stays high briefly after start
        clear_ram();
        run_frame(2, 1'b0);
        finish_frame(3, 20, 2);
        check_ram(2, "f2");

        // Reset mid-frame after 300 transfers with random gaps
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            push(sval(3, n + 500));
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", outs_nz(), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_ready", ready[0], 1'b1);
        chk("midrst_cnt", cnt[0], 8'd0);

        // Frame 3: full frame with gaps must restart at n=0
        clear_ram();
        run_frame(3, 1'b1);
        finish_frame(2, 10, 1);
        check_ram(3, "f3");

        chk("onehot_we", onehot_err, 0);
        chk("writes_while_busy", busy_wr, 0);
        chk("start_width", start_long, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got time limit expected finish");
        $fatal(1, "timeout");
    end

endmodule
